// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ALU.
// Opcodes 0..3 keep the legacy 2-bit encoding with a zero MSB.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_AND  = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_SUB  = 3'd4,
    OP_XOR  = 3'd5,
    OP_ADDC = 3'd6,
    OP_CMP  = 3'd7
  } op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDC) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor: a + (invert_b ? ~b : b) + carry_in,
// with carry-out and signed overflow taken on the effective B operand.
module alu_addsub #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_invert_b,
  input  logic             i_carry_in,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_out,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;

  assign w_b         = i_invert_b ? ~i_b : i_b;
  assign w_sum       = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_carry_in};
  assign o_result    = w_sum[WIDTH-1:0];
  assign o_carry_out = w_sum[WIDTH];
  assign o_overflow  = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 holds the operand beat, S2 holds result and flags.
// Flags are committed to flags_q on the same edge an op moves from S1 into S2.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       flags_q
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  op_e              r_s1_op;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic [3:0]       r_out_flags;
  logic [3:0]       r_flags_q;

  logic             w_s2_adv;
  logic             w_s1_xfer;
  logic             w_take;
  logic             w_invert_b;
  logic             w_carry_in;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry_out;
  logic             w_overflow;
  logic             w_arith;
  logic [WIDTH-1:0] w_logic_res;
  logic [WIDTH-1:0] w_flag_src;
  logic [WIDTH-1:0] w_result;
  logic [3:0]       w_flags;

  assign w_s2_adv  = !r_out_valid || out_ready;
  assign w_s1_xfer = r_s1_valid && w_s2_adv;
  assign in_ready  = !rst && !flush && (!r_s1_valid || w_s2_adv);
  assign w_take    = in_valid && in_ready;

  assign w_invert_b = (r_s1_op == OP_SUB) || (r_s1_op == OP_CMP);
  assign w_carry_in = w_invert_b || ((r_s1_op == OP_ADDC) && r_flags_q[FLAG_C]);
  assign w_arith    = is_arith(r_s1_op);

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .i_a        (r_s1_a),
    .i_b        (r_s1_b),
    .i_invert_b (w_invert_b),
    .i_carry_in (w_carry_in),
    .o_result   (w_sum),
    .o_carry_out(w_carry_out),
    .o_overflow (w_overflow)
  );

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    w_logic_res = '0;
    case (r_s1_op)
      OP_AND:  w_logic_res = r_s1_a & r_s1_b;
      OP_NAND: w_logic_res = ~(r_s1_a & r_s1_b);
      OP_NOR:  w_logic_res = ~(r_s1_a | r_s1_b);
      OP_XOR:  w_logic_res = r_s1_a ^ r_s1_b;
      default: w_logic_res = '0;
    endcase
  end

  // CMP reports A on the result bus while Z/N still describe the difference.
  always_comb begin
    w_flag_src      = w_arith ? w_sum : w_logic_res;
    w_result        = (r_s1_op == OP_CMP) ? r_s1_a : w_flag_src;
    w_flags         = r_flags_q;
    w_flags[FLAG_Z] = (w_flag_src == '0);
    w_flags[FLAG_N] = w_flag_src[WIDTH-1];
    if (w_arith) begin
      w_flags[FLAG_C] = w_carry_out;
      w_flags[FLAG_V] = w_overflow;
    end
  end

  // NOTE: the S1 payload carries no reset; it is only observed while r_s1_valid
  // is set, so clearing it would add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_s1_a  <= in_a;
      r_s1_b  <= in_b;
      r_s1_op <= op_e'(in_op);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
      r_flags_q    <= '0;
    end else if (flush) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_s1_xfer) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_result;
        r_out_flags  <= w_flags;
        r_flags_q    <= w_flags;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_take) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_xfer) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;
  assign flags_q    = r_flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: hand-computed results/flags, latency, backpressure,
// flush and reset behaviour, with an in-order scoreboard on the output port.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 18;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic [3:0]   flags_q;

  alu_pipe #(.WIDTH(W), .OP_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags),
    .flags_q   (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one beat until accepted; the expectation is queued once it is taken.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic [3:0] flg);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    check("accept", {31'd0, ok}, 32'd1);
    if (ok) exp_q.push_back('{res, flg});
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("no_dup", {31'd0, out_valid}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {14'd0, out_result}, {14'd0, mon_e.res});
        check("out_flags", {28'd0, out_flags}, {28'd0, mon_e.flg});
        check("flags_q", {28'd0, flags_q}, {28'd0, mon_e.flg});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 3'd0;
    flush     = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {14'd0, out_result}, 32'd0);
    check("rst_out_flags", {28'd0, out_flags}, 32'd0);
    check("rst_flags_q", {28'd0, flags_q}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Latency: accepted at edge T, visible after T+1.
    issue(OP_ADD, 18'h3FFFF, 18'h00001, 18'h00000, 4'b1010);
    @(negedge clk);
    check("lat_t0", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_t1", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    issue(OP_SUB,  18'h00005, 18'h00007, 18'h3FFFE, 4'b0100);
    issue(OP_AND,  18'h3FFFF, 18'h00F0F, 18'h00F0F, 4'b0000);
    issue(OP_ADD,  18'h3FFFF, 18'h3FFFF, 18'h3FFFE, 4'b0110);
    issue(OP_XOR,  18'h00155, 18'h00155, 18'h00000, 4'b1010);
    issue(OP_ADD,  18'h1FFFF, 18'h00001, 18'h20000, 4'b0101);
    issue(OP_ADD,  18'h3FFFF, 18'h00001, 18'h00000, 4'b1010);
    issue(OP_ADDC, 18'h00000, 18'h00000, 18'h00001, 4'b0000);
    issue(OP_CMP,  18'h00010, 18'h00010, 18'h00010, 4'b1010);
    issue(OP_NAND, 18'h00000, 18'h00000, 18'h3FFFF, 4'b0110);
    issue(OP_CMP,  18'h00003, 18'h00005, 18'h00003, 4'b0100);
    issue(OP_NOR,  18'h3FF00, 18'h000F0, 18'h0000F, 4'b0000);
    issue(OP_SUB,  18'h20000, 18'h00001, 18'h1FFFF, 4'b0011);
    drain();

    // Backpressure: two ops fill the pipe, the rest wait for out_ready.
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        issue(OP_XOR,  18'h12345, 18'h0F0F0, 18'h1D3B5, 4'b0011);
        issue(OP_ADDC, 18'h00100, 18'h00200, 18'h00301, 4'b0000);
        issue(OP_SUB,  18'h00000, 18'h00001, 18'h3FFFF, 4'b0100);
        issue(OP_ADDC, 18'h00001, 18'h3FFFF, 18'h00000, 4'b1010);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_a", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_a", {14'd0, out_result}, 32'h1D3B5);
        @(negedge clk);
        check("bp_in_ready_b", {31'd0, in_ready}, 32'd0);
        check("bp_hold_b", {14'd0, out_result}, 32'h1D3B5);
        check("bp_hold_flags", {28'd0, out_flags}, 32'h3);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two ops in flight; flags_q keeps the op already in S2.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(OP_ADD, 18'h3FFFF, 18'h00002, 18'h00001, 4'b0010);
    issue(OP_XOR, 18'h00000, 18'h00000, 18'h00000, 4'b1010);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = OP_ADD;
    in_a     = 18'h00007;
    in_b     = 18'h00007;
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_flags_q", {28'd0, flags_q}, 32'h2);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("flush_no_stale", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    issue(OP_ADDC, 18'h00000, 18'h00000, 18'h00001, 4'b0000);
    drain();

    // Reset with two ops in flight clears everything including flags_q.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(OP_ADD, 18'h3FFFF, 18'h3FFFF, 18'h3FFFE, 4'b0110);
    issue(OP_SUB, 18'h00001, 18'h00001, 18'h00000, 4'b1010);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_flags_q", {28'd0, flags_q}, 32'd0);
    check("rst2_out_flags", {28'd0, out_flags}, 32'd0);
    check("rst2_result", {14'd0, out_result}, 32'd0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rst2_no_stale", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    issue(OP_ADDC, 18'h00000, 18'h00000, 18'h00000, 4'b1000);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
